// File: rtl/date_edit_sequencer.sv
// rtl/date_edit_sequencer.sv - panel button sequencer for month/day/year edit; `DATE_EDIT_AUTOREPEAT_EN enables held-button auto-repeat
module date_edit_sequencer #(
    parameter int TIMEOUT_MS      = 10000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int BLINK_MS        = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] en,
    output logic       aumento,
    output logic       disminuye,
    output logic       wr_commit,
    output logic       timeout_abort,
    output logic       editing,
    output logic       blink
);

    localparam int TO_W = $clog2(TIMEOUT_MS) + 1;
    localparam int BL_W = $clog2(BLINK_MS) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MS - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_MS - 1);

    typedef enum logic [1:0] {RUN, EDIT, COMMIT} state_t;

    state_t          state, state_n;
    logic            mode_prev, up_prev, down_prev;
    logic            mode_rise, up_rise, down_rise, any_held;
    logic [TO_W-1:0] inact, inact_n;
    logic [BL_W-1:0] blink_cnt, blink_cnt_n;
    logic [1:0]      en_n;
    logic            aum_n, dis_n, wrc_n, abort_n, blink_n;
    logic            rep_up, rep_down;

    assign mode_rise = btn_mode & ~mode_prev;
    assign up_rise   = btn_up & ~up_prev;
    assign down_rise = btn_down & ~down_prev;
    assign any_held  = btn_mode | btn_up | btn_down;

`ifdef DATE_EDIT_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

    logic [HOLD_W-1:0] hold_cnt, hold_last;
    logic              rep_phase, one_held, hold_run, rep_fire;

    // First threshold is the initial delay; after the first repeat the rate applies.
    assign one_held  = btn_up ^ btn_down;
    assign hold_run  = (state == EDIT) && one_held && !mode_rise;
    assign hold_last = rep_phase ? HOLD_W'(REPEAT_RATE_MS - 1) : HOLD_W'(REPEAT_DELAY_MS - 1);
    assign rep_fire  = hold_run && tick_ms && (hold_cnt == hold_last);
    assign rep_up    = rep_fire & btn_up;
    assign rep_down  = rep_fire & btn_down;

    always_ff @(posedge clk) begin
        if (rst || !hold_run) begin
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
        end else if (tick_ms) begin
            if (hold_cnt == hold_last) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_up   = 1'b0;
    assign rep_down = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        en_n        = en;
        aum_n       = 1'b0;
        dis_n       = 1'b0;
        wrc_n       = 1'b0;
        abort_n     = 1'b0;
        blink_n     = blink;
        inact_n     = inact;
        blink_cnt_n = blink_cnt;
        case (state)
            RUN: begin
                en_n        = 2'd0;
                blink_n     = 1'b0;
                inact_n     = '0;
                blink_cnt_n = '0;
                if (mode_rise) begin
                    state_n = EDIT;
                    en_n    = 2'd1;
                    blink_n = 1'b1;
                end
            end
            EDIT: begin
                // A held button covers the rise cycle too, so a coincident tick never counts.
                if (any_held)
                    inact_n = '0;
                else if (tick_ms)
                    inact_n = inact + 1'b1;
                if (tick_ms) begin
                    if (blink_cnt == BL_LAST) begin
                        blink_cnt_n = '0;
                        blink_n     = ~blink;
                    end else begin
                        blink_cnt_n = blink_cnt + 1'b1;
                    end
                end
                if (mode_rise) begin
                    if (en == 2'd3) begin
                        state_n = COMMIT;
                        wrc_n   = 1'b1;
                        blink_n = 1'b0;
                    end else begin
                        en_n = en + 2'd1;
                    end
                end else if (!any_held && tick_ms && inact == TO_LAST) begin
                    state_n = RUN;
                    en_n    = 2'd0;
                    abort_n = 1'b1;
                    blink_n = 1'b0;
                end else begin
                    aum_n = (up_rise | rep_up) & ~btn_down;
                    dis_n = (down_rise | rep_down) & ~btn_up;
                end
            end
            default: begin
                state_n = RUN;
                en_n    = 2'd0;
                blink_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            en            <= 2'd0;
            aumento       <= 1'b0;
            disminuye     <= 1'b0;
            wr_commit     <= 1'b0;
            timeout_abort <= 1'b0;
            editing       <= 1'b0;
            blink         <= 1'b0;
            inact         <= '0;
            blink_cnt     <= '0;
            mode_prev     <= 1'b1;
            up_prev       <= 1'b1;
            down_prev     <= 1'b1;
        end else begin
            state         <= state_n;
            en            <= en_n;
            aumento       <= aum_n;
            disminuye     <= dis_n;
            wr_commit     <= wrc_n;
            timeout_abort <= abort_n;
            editing       <= (state_n == EDIT);
            blink         <= blink_n;
            inact         <= inact_n;
            blink_cnt     <= blink_cnt_n;
            mode_prev     <= btn_mode;
            up_prev       <= btn_up;
            down_prev     <= btn_down;
        end
    end

endmodule
